blackjack_table: RTL and testbench

Parametrised multi-player blackjack round controller, the successor to the single-player `blackjack` game block. It serves `NPLAYERS` players plus one dealer from a seeded LFSR card source. It sequences deal, player turns, the dealer turn and resolution, and publishes per-player hand values and win/lose/push flags. It sits between the button/switch debouncers and the seven-segment/LED display logic.

---
 rtl/blackjack_pkg.sv | 28 ++
 rtl/card_lfsr.sv | 52 +++++
 rtl/blackjack_table.sv | 227 ++++++++++++++++++++++
 tb/tb_blackjack_table.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared state encoding, card decode and hand-value arithmetic for the blackjack table.
package blackjack_pkg;
   localparam int unsigned HAND_W = 6;
   localparam int unsigned CARD_W = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_DEAL, S_PLAYER, S_DEALER, S_RESOLVE, S_DONE
   } state_e;

   // Raw 4-bit field to card value: 0 is an ace, 10..15 are ten-valued cards.
   function automatic logic [CARD_W-1:0] card_decode(input logic [CARD_W-1:0] v);
      logic [CARD_W-1:0] c;
      if (v == CARD_W'(0))       c = CARD_W'(1);
      else if (v >= CARD_W'(10)) c = CARD_W'(10);
      else                       c = v;
      return c;
   endfunction

   // One ace counts as eleven whenever that keeps the hand within the limit.
   function automatic logic [HAND_W-1:0] hand_value(input logic [HAND_W-1:0] hard,
                                                    input logic              has_ace,
                                                    input int unsigned       limit);
      logic [HAND_W-1:0] v;
      v = hard;
      if (has_ace && (32'(hard) + 32'd10 <= limit)) v = hard + HAND_W'(10);
      return v;
   endfunction
endpackage

// File: rtl/card_lfsr.sv
// Seeded Fibonacci LFSR card source; advances once per drawn card.
module card_lfsr
   import blackjack_pkg::*;
#(
   parameter int unsigned LFSR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [CARD_W-1:0] card_c
);
   // Feedback taps (bit index = exponent-1) of a maximal-length polynomial per width.
   function automatic logic [LFSR_W-1:0] tap_mask();
      logic [31:0] m;
      case (LFSR_W)
         4:       m = 32'h0000_000C;
         5:       m = 32'h0000_0014;
         6:       m = 32'h0000_0030;
         7:       m = 32'h0000_0060;
         8:       m = 32'h0000_00B8;
         9:       m = 32'h0000_0110;
         10:      m = 32'h0000_0240;
         11:      m = 32'h0000_0500;
         12:      m = 32'h0000_0829;
         13:      m = 32'h0000_100D;
         14:      m = 32'h0000_2015;
         15:      m = 32'h0000_6000;
         16:      m = 32'h0000_D008;
         default: m = 32'd3 << (LFSR_W - 2);
      endcase
      return m[LFSR_W-1:0];
   endfunction

   localparam logic [LFSR_W-1:0] TAPS = tap_mask();

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load)         lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
      else if (advance) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr_q <= LFSR_W'(1);
      else        lfsr_q <= lfsr_d;
   end

   assign card_c = card_decode(lfsr_q[CARD_W-1:0]);
endmodule

// File: rtl/blackjack_table.sv
// Multi-player blackjack round controller: deal, player turns, dealer turn, resolve.
module blackjack_table
   import blackjack_pkg::*;
#(
   parameter int unsigned NPLAYERS = 2,
   parameter int unsigned LIMIT    = 21,
   parameter int unsigned STAND    = 17,
   parameter int unsigned LFSR_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       hit,
   input  logic                       pass,
   input  logic [LFSR_W-1:0]          seed,
   input  logic                       card_load,
   input  logic [CARD_W-1:0]          card_in,
   output logic [NPLAYERS*HAND_W-1:0] hand_pl,
   output logic [HAND_W-1:0]          hand_dl,
   output logic [1:0]                 active,
   output logic                       busy,
   output logic                       done,
   output logic [NPLAYERS-1:0]        winner,
   output logic [NPLAYERS-1:0]        loser,
   output logic [NPLAYERS-1:0]        push,
   output logic [NPLAYERS-1:0]        bust
);
   localparam int unsigned NSEATS   = NPLAYERS + 1;
   localparam int unsigned DEAL_LEN = 2 * NSEATS;
   localparam int unsigned CNT_W    = $clog2(DEAL_LEN);
   localparam int unsigned SEAT_W   = 3;
   localparam logic [HAND_W-1:0] LIM_H   = HAND_W'(LIMIT);
   localparam logic [HAND_W-1:0] STAND_H = HAND_W'(STAND);

   state_e                     state_q, state_d;
   logic [HAND_W-1:0]          hard_q [NSEATS];
   logic [HAND_W-1:0]          hard_d [NSEATS];
   logic [HAND_W-1:0]          val_c  [NSEATS];
   logic                       ace_q  [NSEATS];
   logic                       ace_d  [NSEATS];
   logic [CNT_W-1:0]           deal_q, deal_d;
   logic [1:0]                 active_q, active_d;
   logic                       busy_q, busy_d, done_q, done_d;
   logic [NPLAYERS-1:0]        winner_q, winner_d, loser_q, loser_d;
   logic [NPLAYERS-1:0]        push_q, push_d, bust_q, bust_d;
   logic [NPLAYERS*HAND_W-1:0] hand_pl_q, hand_pl_d;
   logic [HAND_W-1:0]          hand_dl_q, hand_dl_d;

   logic                       draw_c, lfsr_load_c, adv_c;
   logic [SEAT_W-1:0]          seat_c;
   logic [CARD_W-1:0]          lfsr_card_c, card_c;
   logic [HAND_W-1:0]          act_hard_c, act_val_c, new_hard_c;
   logic                       act_ace_c, new_ace_c, all_bust_c, dl_bust_c;

   card_lfsr #(.LFSR_W(LFSR_W)) u_card_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (lfsr_load_c),
      .seed    (seed),
      .advance (draw_c),
      .card_c  (lfsr_card_c)
   );

   assign card_c = card_load ? card_in : lfsr_card_c;

   always_comb begin
      for (int unsigned s = 0; s < NSEATS; s++) val_c[s] = hand_value(hard_q[s], ace_q[s], LIMIT);
   end

   // Active player's hand, the hand it would become on a hit, and table-wide bust status.
   always_comb begin
      act_hard_c = '0;
      act_ace_c  = 1'b0;
      act_val_c  = '0;
      all_bust_c = 1'b1;
      for (int unsigned i = 0; i < NPLAYERS; i++) begin
         if (active_q == 2'(i)) begin
            act_hard_c = hard_q[i];
            act_ace_c  = ace_q[i];
            act_val_c  = val_c[i];
         end
         if (hard_q[i] <= LIM_H) all_bust_c = 1'b0;
      end
      new_hard_c = act_hard_c + HAND_W'(card_c);
      new_ace_c  = act_ace_c | (card_c == CARD_W'(1));
      dl_bust_c  = hard_q[NPLAYERS] > LIM_H;
   end

   always_comb begin
      state_d     = state_q;
      hard_d      = hard_q;
      ace_d       = ace_q;
      deal_d      = deal_q;
      active_d    = active_q;
      winner_d    = winner_q;
      loser_d     = loser_q;
      push_d      = push_q;
      draw_c      = 1'b0;
      seat_c      = '0;
      lfsr_load_c = 1'b0;
      adv_c       = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               lfsr_load_c = 1'b1;
               state_d     = S_DEAL;
               deal_d      = '0;
               active_d    = '0;
               winner_d    = '0;
               loser_d     = '0;
               push_d      = '0;
               for (int unsigned s = 0; s < NSEATS; s++) begin
                  hard_d[s] = '0;
                  ace_d[s]  = 1'b0;
               end
            end
         end
         S_DEAL: begin
            // Two passes round the table, players first then dealer.
            draw_c = 1'b1;
            seat_c = (deal_q < CNT_W'(NSEATS)) ? SEAT_W'(deal_q) : SEAT_W'(deal_q - CNT_W'(NSEATS));
            if (deal_q == CNT_W'(DEAL_LEN - 1)) begin
               state_d  = S_PLAYER;
               active_d = '0;
            end else begin
               deal_d = deal_q + CNT_W'(1);
            end
         end
         S_PLAYER: begin
            seat_c = SEAT_W'(active_q);
            if (act_val_c == LIM_H || pass) begin
               adv_c = 1'b1;
            end else if (hit) begin
               draw_c = 1'b1;
               if (new_hard_c > LIM_H || hand_value(new_hard_c, new_ace_c, LIMIT) == LIM_H) adv_c = 1'b1;
            end
            if (adv_c) begin
               if (active_q == 2'(NPLAYERS - 1)) state_d  = S_DEALER;
               else                               active_d = active_q + 2'd1;
            end
         end
         S_DEALER: begin
            if (all_bust_c || val_c[NPLAYERS] >= STAND_H) begin
               state_d = S_RESOLVE;
            end else begin
               draw_c = 1'b1;
               seat_c = SEAT_W'(NPLAYERS);
            end
         end
         S_RESOLVE: begin
            for (int unsigned i = 0; i < NPLAYERS; i++) begin
               winner_d[i] = 1'b0;
               loser_d[i]  = 1'b0;
               push_d[i]   = 1'b0;
               if (hard_q[i] > LIM_H)                             loser_d[i]  = 1'b1;
               else if (dl_bust_c || val_c[i] > val_c[NPLAYERS]) winner_d[i] = 1'b1;
               else if (val_c[i] < val_c[NPLAYERS])              loser_d[i]  = 1'b1;
               else                                               push_d[i]   = 1'b1;
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (draw_c) begin
         for (int unsigned s = 0; s < NSEATS; s++) begin
            if (seat_c == SEAT_W'(s)) begin
               hard_d[s] = hard_q[s] + HAND_W'(card_c);
               ace_d[s]  = ace_q[s] | (card_c == CARD_W'(1));
            end
         end
      end

      hand_pl_d = '0;
      bust_d    = '0;
      for (int unsigned i = 0; i < NPLAYERS; i++) begin
         hand_pl_d[i*HAND_W +: HAND_W] = hand_value(hard_d[i], ace_d[i], LIMIT);
         bust_d[i] = hard_d[i] > LIM_H;
      end
      hand_dl_d = hand_value(hard_d[NPLAYERS], ace_d[NPLAYERS], LIMIT);
      busy_d    = state_d inside {S_DEAL, S_PLAYER, S_DEALER, S_RESOLVE};
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         hard_q    <= '{default: '0};
         ace_q     <= '{default: 1'b0};
         deal_q    <= '0;
         active_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         winner_q  <= '0;
         loser_q   <= '0;
         push_q    <= '0;
         bust_q    <= '0;
         hand_pl_q <= '0;
         hand_dl_q <= '0;
      end else begin
         state_q   <= state_d;
         hard_q    <= hard_d;
         ace_q     <= ace_d;
         deal_q    <= deal_d;
         active_q  <= active_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         winner_q  <= winner_d;
         loser_q   <= loser_d;
         push_q    <= push_d;
         bust_q    <= bust_d;
         hand_pl_q <= hand_pl_d;
         hand_dl_q <= hand_dl_d;
      end
   end

   assign hand_pl = hand_pl_q;
   assign hand_dl = hand_dl_q;
   assign active  = active_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign winner  = winner_q;
   assign loser   = loser_q;
   assign push    = push_q;
   assign bust    = bust_q;
endmodule

// File: tb/tb_blackjack_table.sv
// Bench for blackjack_table: scripted and randomized rounds checked against a card-level game model.
module tb_blackjack_table;
   localparam int NP = 2;
   localparam int NS = NP + 1;

   logic          clk = 1'b0;
   logic          reset, start, hit, pass, card_load;
   logic [7:0]    seed_i;
   logic [3:0]    card_in;
   logic [NP*6-1:0] hand_pl;
   logic [5:0]    hand_dl;
   logic [1:0]    active;
   logic          busy, done;
   logic [NP-1:0] winner, loser, push, bust;

   int checks   = 0;
   int failures = 0;

   int m_hard[NS];
   bit m_ace[NS];
   int lf;
   bit ovr;
   int ovr_q[$];

   blackjack_table #(.NPLAYERS(NP), .LIMIT(21), .STAND(17), .LFSR_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .hit(hit), .pass(pass), .seed(seed_i),
      .card_load(card_load), .card_in(card_in), .hand_pl(hand_pl), .hand_dl(hand_dl),
      .active(active), .busy(busy), .done(done), .winner(winner), .loser(loser),
      .push(push), .bust(bust)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_val(input int s);
      return (m_ace[s] && m_hard[s] + 10 <= 21) ? m_hard[s] + 10 : m_hard[s];
   endfunction

   function automatic logic [5:0] pl(input int i);
      return hand_pl[i*6 +: 6];
   endfunction

   // Next card of the shoe (override queue or LFSR x^8+x^6+x^5+x^4+1), dealt into seat s.
   task automatic take_card(input int s);
      int v, c, fb;
      c = 0;
      if (ovr) c = ovr_q.pop_front();
      else begin
         v = lf % 16;
         c = (v == 0) ? 1 : ((v >= 10) ? 10 : v);
      end
      fb = ((lf >> 7) ^ (lf >> 5) ^ (lf >> 4) ^ (lf >> 3)) & 1;
      lf = ((lf << 1) | fb) & 255;
      if (ovr) card_in = 4'(c);
      m_hard[s] += c;
      if (c == 1) m_ace[s] = 1'b1;
   endtask

   // Players hit while their value is below thr, then pass; dealer draws below 17 unless all players bust.
   task automatic play_round(input string nm, input int sd, input bit use_ovr,
                             input int thr0, input int thr1, input bit both, input bit gaps);
      int thr[NP];
      int dv, pv, s;
      bit allb, dbust, turn_over;
      logic [NP-1:0] ew, el, ep, eb;
      logic [NP*6-1:0] ehp;
      thr[0] = thr0;
      thr[1] = thr1;
      ovr = use_ovr;
      card_load = use_ovr;
      card_in = 4'd1;
      lf = (sd % 256 == 0) ? 1 : sd % 256;
      for (int k = 0; k < NS; k++) begin
         m_hard[k] = 0;
         m_ace[k] = 1'b0;
      end
      seed_i = 8'(sd);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({nm, "_busy_start"}, busy, 1);
      check({nm, "_clear"}, hand_pl, 0);
      for (int k = 0; k < 2 * NS; k++) begin
         s = k % NS;
         take_card(s);
         tick();
         if (s < NP) check({nm, "_deal_pl"}, pl(s), m_val(s));
         else        check({nm, "_deal_dl"}, hand_dl, m_val(NP));
      end
      for (int i = 0; i < NP; i++) begin
         check({nm, "_active"}, active, i);
         if (m_val(i) == 21) begin
            tick();
         end else begin
            turn_over = 1'b0;
            while (!turn_over) begin
               if (gaps && $urandom_range(0, 2) == 0) begin
                  start = 1'b1;
                  tick();
                  start = 1'b0;
                  check({nm, "_gap_hand"}, pl(i), m_val(i));
                  check({nm, "_gap_active"}, active, i);
               end
               if (m_val(i) < thr[i]) begin
                  hit = 1'b1;
                  take_card(i);
                  tick();
                  hit = 1'b0;
                  check({nm, "_hit_hand"}, pl(i), m_val(i));
                  check({nm, "_hit_bust"}, bust[i], m_hard[i] > 21);
                  if (m_hard[i] > 21 || m_val(i) == 21) turn_over = 1'b1;
                  else check({nm, "_hit_active"}, active, i);
               end else begin
                  pass = 1'b1;
                  hit = both || ($urandom_range(0, 3) == 0);
                  tick();
                  pass = 1'b0;
                  hit = 1'b0;
                  check({nm, "_pass_hand"}, pl(i), m_val(i));
                  turn_over = 1'b1;
               end
            end
         end
      end
      allb = 1'b1;
      for (int i = 0; i < NP; i++) if (m_hard[i] <= 21) allb = 1'b0;
      while (!allb && m_val(NP) < 17) begin
         take_card(NP);
         tick();
         check({nm, "_dl_draw"}, hand_dl, m_val(NP));
         check({nm, "_dl_busy"}, busy, 1);
      end
      tick();
      check({nm, "_resolve_notdone"}, done, 0);
      tick();
      check({nm, "_done"}, done, 1);
      check({nm, "_busy_end"}, busy, 0);
      dv = m_val(NP);
      dbust = m_hard[NP] > 21;
      ew = '0; el = '0; ep = '0; eb = '0; ehp = '0;
      for (int i = 0; i < NP; i++) begin
         pv = m_val(i);
         ehp[i*6 +: 6] = 6'(pv);
         eb[i] = m_hard[i] > 21;
         if (eb[i])                   el[i] = 1'b1;
         else if (dbust || pv > dv)   ew[i] = 1'b1;
         else if (pv < dv)            el[i] = 1'b1;
         else                         ep[i] = 1'b1;
      end
      check({nm, "_hand_pl"}, hand_pl, ehp);
      check({nm, "_hand_dl"}, hand_dl, dv);
      check({nm, "_winner"}, winner, ew);
      check({nm, "_loser"}, loser, el);
      check({nm, "_push"}, push, ep);
      check({nm, "_bust"}, bust, eb);
      hit = 1'b1;
      pass = 1'b1;
      tick();
      hit = 1'b0;
      pass = 1'b0;
      check({nm, "_done_hold"}, done, 1);
      check({nm, "_done_hand"}, hand_pl, ehp);
      check({nm, "_done_winner"}, winner, ew);
      card_load = 1'b0;
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_hand_pl"}, hand_pl, 0);
      check({nm, "_hand_dl"}, hand_dl, 0);
      check({nm, "_active"}, active, 0);
      check({nm, "_busy"}, busy, 0);
      check({nm, "_done"}, done, 0);
      check({nm, "_flags"}, {winner, loser, push, bust}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; start = 1'b0; hit = 1'b0; pass = 1'b0;
      seed_i = 8'd0; card_load = 1'b0; card_in = 4'd1;
      tick();
      tick();
      check_reset_outputs("por");
      reset = 1'b1;
      tick();

      // Natural for P0 is skipped; P1 stands on 14; dealer 17 stands.
      ovr_q = '{10, 9, 7, 1, 5, 10};
      play_round("nat", 8'h11, 1'b1, 0, 0, 1'b0, 1'b0);
      check("nat_winner_k", winner, 2'b01);
      check("nat_loser_k", loser, 2'b10);
      check("nat_dl_k", hand_dl, 17);

      // P0 10,6 hits a 10 and busts; dealer soft 17 stands.
      ovr_q = '{10, 10, 1, 6, 8, 6, 10};
      play_round("bust", 8'h22, 1'b1, 21, 0, 1'b0, 1'b0);
      check("bust_hand_k", pl(0), 26);
      check("bust_flag_k", bust, 2'b01);
      check("bust_loser_k", loser, 2'b01);
      check("bust_winner_k", winner, 2'b10);

      // Both players 17 against a soft 17, passing with hit+pass held together.
      ovr_q = '{10, 9, 1, 7, 8, 6};
      play_round("push", 8'h33, 1'b1, 0, 0, 1'b1, 1'b0);
      check("push_flags_k", push, 2'b11);
      check("push_dl_k", hand_dl, 17);

      play_round("seed1", 1, 1'b0, 17, 15, 1'b0, 1'b1);
      play_round("seed0", 0, 1'b0, 17, 15, 1'b0, 1'b1);

      // Reset in the middle of the deal.
      seed_i = 8'h5A;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      tick();
      reset = 1'b1;
      tick();
      check_reset_outputs("rst_after");

      for (int r = 0; r < 40; r++) begin
         play_round("rnd", int'($urandom_range(0, 255)), 1'b0, int'($urandom_range(0, 22)),
                    int'($urandom_range(0, 22)), 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
